// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, instruction kinds and loader states shared by the loader and the control decoder
package cpu_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    typedef enum logic [2:0] {
        KIND_R, KIND_ADDI, KIND_BEQ, KIND_BNE, KIND_SLTI, KIND_SLTIU, KIND_LUI, KIND_ORI
    } kind_e;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FLUSH, ST_DONE} ld_state_e;

    function automatic logic [5:0] kind_opcode(kind_e k);
        case (k)
            KIND_R:     return OP_RTYPE;
            KIND_ADDI:  return OP_ADDI;
            KIND_BEQ:   return OP_BEQ;
            KIND_BNE:   return OP_BNE;
            KIND_SLTI:  return OP_SLTI;
            KIND_SLTIU: return OP_SLTIU;
            KIND_LUI:   return OP_LUI;
            default:    return OP_ORI;
        endcase
    endfunction
endpackage

// File: rtl/instr_field_packer.sv
// instr_field_packer: combinational packing of an instruction kind and its fields into a 32-bit MIPS word
// Ports: kind_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i -> word_o
module instr_field_packer
    import cpu_pkg::*;
(
    input  logic [2:0]  kind_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] imm_i,
    output logic [31:0] word_o
);
    kind_e kind;
    assign kind = kind_e'(kind_i);
    // lui has no source register, so its rs field is forced to zero
    always_comb
        word_o = (kind == KIND_R) ? {OP_RTYPE, rs_i, rt_i, rd_i, shamt_i, funct_i}
                                  : {kind_opcode(kind), (kind == KIND_LUI) ? 5'd0 : rs_i, rt_i, imm_i};
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: accepts instruction requests, encodes them and writes them into instruction memory
// Ports: clk_i/rst_i; start_i; req_* valid/ready request channel; mem_we_o/mem_addr_o/mem_wdata_o write port;
//        cpu_hold_o, busy_o, done_o, err_o, count_o status
module instr_encoder_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_kind_i,
    input  logic [4:0]        req_rs_i,
    input  logic [4:0]        req_rt_i,
    input  logic [4:0]        req_rd_i,
    input  logic [4:0]        req_shamt_i,
    input  logic [5:0]        req_funct_i,
    input  logic [15:0]       req_imm_i,
    input  logic              req_last_i,
    output logic              mem_we_o,
    output logic [ADDR_W+1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   count_o
);
    ld_state_e         state_q, state_d;
    logic [ADDR_W:0]   acc_q, acc_d, cnt_q, cnt_d;
    logic              err_q, err_d, we_q, we_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d, word;
    logic              hs, full_next;

    instr_field_packer u_packer (
        .kind_i  (req_kind_i),
        .rs_i    (req_rs_i),
        .rt_i    (req_rt_i),
        .rd_i    (req_rd_i),
        .shamt_i (req_shamt_i),
        .funct_i (req_funct_i),
        .imm_i   (req_imm_i),
        .word_o  (word)
    );

    // the top bit of the accepted count set means DEPTH words have been taken
    assign req_ready_o = (state_q == ST_LOAD) && !acc_q[ADDR_W];
    assign hs          = req_valid_i && req_ready_o;
    assign full_next   = &acc_q[ADDR_W-1:0];

    always_comb begin
        state_d = state_q;
        acc_d   = hs ? acc_q + 1'b1 : acc_q;
        cnt_d   = cnt_q + {{ADDR_W{1'b0}}, we_q};
        err_d   = err_q;
        we_d    = hs;
        // each accepted word is written one cycle later at 4x its acceptance index
        addr_d  = hs ? {acc_q[ADDR_W-1:0], 2'b00} : addr_q;
        wdata_d = hs ? word : wdata_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start_i) begin
                state_d = ST_LOAD;
                acc_d   = '0;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
            ST_LOAD: if (hs && (req_last_i || full_next)) begin
                state_d = ST_FLUSH;
                err_d   = !req_last_i;
            end
            default: state_d = ST_DONE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
    assign cpu_hold_o  = busy_o;
    assign done_o      = state_q == ST_DONE;
    assign err_o       = err_q;
    assign count_o     = cnt_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed checks of encoding, timing, reset abort, stalls and depth overflow
module tb_instr_encoder_loader;
    logic        clk = 0, rst, start, start2, valid, last;
    logic [2:0]  kind;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic        ready, we, hold, busy, done, err;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [5:0]  count;
    logic        ready2, we2, hold2, busy2, done2, err2;
    logic [3:0]  addr2;
    logic [31:0] wdata2;
    logic [2:0]  count2;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    instr_encoder_loader dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .req_valid_i(valid), .req_ready_o(ready),
        .req_kind_i(kind), .req_rs_i(rs), .req_rt_i(rt), .req_rd_i(rd), .req_shamt_i(shamt),
        .req_funct_i(funct), .req_imm_i(imm), .req_last_i(last), .mem_we_o(we), .mem_addr_o(addr),
        .mem_wdata_o(wdata), .cpu_hold_o(hold), .busy_o(busy), .done_o(done), .err_o(err), .count_o(count)
    );

    instr_encoder_loader #(.ADDR_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .req_valid_i(valid), .req_ready_o(ready2),
        .req_kind_i(kind), .req_rs_i(rs), .req_rt_i(rt), .req_rd_i(rd), .req_shamt_i(shamt),
        .req_funct_i(funct), .req_imm_i(imm), .req_last_i(last), .mem_we_o(we2), .mem_addr_o(addr2),
        .mem_wdata_o(wdata2), .cpu_hold_o(hold2), .busy_o(busy2), .done_o(done2), .err_o(err2), .count_o(count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] k, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                       input logic [5:0] f, input logic [15:0] i, input logic l);
        valid = 1; kind = k; rs = s; rt = t; rd = d; shamt = 0; funct = f; imm = i; last = l;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_outs"}, {ready, we, hold, busy, done, err}, 0);
        chk({tag, "_addr"}, {25'd0, addr}, 0);
        chk({tag, "_data"}, wdata, 0);
        chk({tag, "_count"}, {26'd0, count}, 0);
    endtask

    task automatic begin_load();
        start = 1;
        step();
        start = 0;
    endtask

    initial begin
        rst = 1; start = 0; start2 = 0; valid = 0; last = 0;
        kind = 0; rs = 0; rt = 0; rd = 0; shamt = 0; funct = 0; imm = 0;
        #1;
        all_zero("reset");
        step();
        rst = 0;
        step();
        all_zero("idle");

        // single addi
        begin_load();
        chk("load_hold", {hold, busy, ready, done}, 4'b1110);
        req(1, 1, 2, 9, 6'h3f, 16'h0005, 1);
        step();
        valid = 0;
        chk("addi_we", we, 1);
        chk("addi_addr", addr, 0);
        chk("addi_data", wdata, 32'h20220005);
        chk("addi_flush", {done, hold, ready}, 3'b010);
        step();
        chk("addi_done", {done, hold, busy, we}, 4'b1000);
        chk("addi_count", count, 1);
        chk("addi_err", err, 0);

        // R-type then beq, back to back, restarted directly from DONE
        begin_load();
        chk("restart_count", count, 0);
        req(0, 1, 2, 3, 6'h20, 16'hABCD, 0);
        step();
        chk("rtype_we", we, 1);
        chk("rtype_addr", addr, 0);
        chk("rtype_data", wdata, 32'h00221820);
        req(2, 3, 0, 7, 6'h11, 16'hFFFF, 1);
        step();
        valid = 0;
        chk("beq_we", we, 1);
        chk("beq_addr", addr, 4);
        chk("beq_data", wdata, 32'h1060FFFF);
        step();
        chk("beq_done", {done, we}, 2'b10);
        chk("beq_count", count, 2);

        // lui forces rs to zero
        begin_load();
        req(6, 7, 4, 0, 0, 16'h1234, 1);
        step();
        valid = 0;
        chk("lui_addr", addr, 0);
        chk("lui_data", wdata, 32'h3C041234);
        step();
        chk("lui_done", done, 1);

        // stall with start pulses during LOAD, then ori with a concurrent start
        begin_load();
        for (int i = 0; i < 3; i++) begin
            start = (i != 1);
            step();
            chk("stall_we", we, 0);
            chk("stall_hold", {hold, busy, done}, 3'b110);
        end
        req(7, 5, 6, 0, 0, 16'h00FF, 1);
        start = 1;
        step();
        valid = 0; start = 0;
        chk("ori_we", we, 1);
        chk("ori_addr", addr, 0);
        chk("ori_data", wdata, 32'h34A600FF);
        step();
        chk("ori_done", done, 1);
        chk("ori_count", count, 1);

        // reset one cycle after a handshake aborts immediately
        begin_load();
        req(4, 2, 3, 0, 0, 16'h0010, 0);
        step();
        req(5, 2, 3, 0, 0, 16'h0020, 0);
        @(posedge clk);
        rst = 1;
        valid = 0;
        #1;
        all_zero("abort");
        step();
        rst = 0;
        step();
        all_zero("abort_idle");
        begin_load();
        req(3, 8, 9, 0, 0, 16'h0003, 1);
        step();
        valid = 0;
        chk("reload_addr", addr, 0);
        chk("reload_data", wdata, 32'h15090003);
        step();
        chk("reload_count", count, 1);

        // depth overflow on a 4-word loader
        start2 = 1;
        step();
        start2 = 0;
        for (int i = 0; i < 4; i++) begin
            req(1, 1, 2, 0, 0, 16'(i), 0);
            chk("ovf_ready", ready2, 1);
            step();
            chk("ovf_we", we2, 1);
            chk("ovf_addr", {28'd0, addr2}, 4 * i);
            chk("ovf_data", wdata2, 32'h20220000 + i);
        end
        req(1, 1, 2, 0, 0, 16'h0004, 0);
        chk("ovf_ready_low", ready2, 0);
        step();
        valid = 0;
        chk("ovf_no_write", we2, 0);
        chk("ovf_done", {done2, hold2, err2}, 3'b101);
        chk("ovf_count", {29'd0, count2}, 4);
        chk("main_unaffected", {we, done}, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
